// File: rtl/core_pkg.sv
// Shared definitions for multicycle_core: opcodes, FSM states, flag bit
// positions and instruction field-position helpers.
package core_pkg;

  localparam int OP_W = 5;

  typedef enum logic [4:0] {
    OP_NOP  = 5'd0,
    OP_MOV  = 5'd1,
    OP_LDI  = 5'd2,
    OP_ADD  = 5'd3,
    OP_SUB  = 5'd4,
    OP_AND  = 5'd5,
    OP_OR   = 5'd6,
    OP_XOR  = 5'd7,
    OP_CMP  = 5'd8,
    OP_ADDI = 5'd9,
    OP_LD   = 5'd10,
    OP_ST   = 5'd11,
    OP_JMP  = 5'd12,
    OP_JZ   = 5'd13,
    OP_JNZ  = 5'd14,
    OP_JL   = 5'd15,
    OP_JG   = 5'd16,
    OP_HLT  = 5'd17
  } opcode_e;

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Flag register layout {Z,L,G}
  localparam int FLAG_Z = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_G = 0;

  // Field LSB positions; op sits at the top, rd and rs follow it.
  function automatic int op_lsb(input int instr_w);
    return instr_w - OP_W;
  endfunction

  function automatic int rd_lsb(input int instr_w, input int reg_aw);
    return instr_w - OP_W - reg_aw;
  endfunction

  function automatic int rs_lsb(input int instr_w, input int reg_aw);
    return instr_w - OP_W - 2 * reg_aw;
  endfunction

  // imm starts right after rd (overlaps rs)
  function automatic int imm_lsb(input int instr_w, input int reg_aw, input int data_w);
    return instr_w - OP_W - reg_aw - data_w;
  endfunction

  // target starts right after op (overlaps rd/rs/imm)
  function automatic int tgt_lsb(input int instr_w, input int pc_w);
    return instr_w - OP_W - pc_w;
  endfunction

  // Lowest instruction bit any field uses; bits below it are never decoded.
  function automatic int used_lsb(input int instr_w, input int reg_aw,
                                  input int data_w, input int pc_w);
    int m;
    m = rs_lsb(instr_w, reg_aw);
    if (imm_lsb(instr_w, reg_aw, data_w) < m) m = imm_lsb(instr_w, reg_aw, data_w);
    if (tgt_lsb(instr_w, pc_w) < m) m = tgt_lsb(instr_w, pc_w);
    return m;
  endfunction

  function automatic logic writes_flags(input logic [4:0] op);
    logic w;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_CMP, OP_ADDI: w = 1'b1;
      default:                                                w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic logic writes_reg(input logic [4:0] op);
    logic w;
    case (op)
      OP_MOV, OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_ADDI: w = 1'b1;
      default:                                                        w = 1'b0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/core_alu.sv
// Combinational ALU for multicycle_core. Produces the result of rd op rs
// (or rd op imm) and the {Z,L,G} flags; L/G are only meaningful for SUB/CMP.
module core_alu
  import core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [4:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] result_o,
  output logic [2:0]        flags_o
);

  // Result and flag generation
  always_comb begin
    result_o = a_i;
    flags_o  = 3'b000;
    case (op_i)
      OP_MOV, OP_LDI:  result_o = b_i;
      OP_ADD, OP_ADDI: result_o = a_i + b_i;
      OP_SUB, OP_CMP: begin
        result_o        = a_i - b_i;
        flags_o[FLAG_L] = (a_i < b_i);
        flags_o[FLAG_G] = (a_i > b_i);
      end
      OP_AND:          result_o = a_i & b_i;
      OP_OR:           result_o = a_i | b_i;
      OP_XOR:          result_o = a_i ^ b_i;
      default:         result_o = a_i;
    endcase
    flags_o[FLAG_Z] = (result_o == '0);
  end

endmodule

// File: rtl/multicycle_core.sv
// Multi-cycle 8-bit core: FETCH/DECODE/EXEC(/MEM) sequencer with program
// load mode, HALT, PC end-of-memory policy and debug readback.
// Optional retired-instruction counter is built when CORE_PERF_CNT_EN is defined.
//
// Handshake: prog_en is a level; while high the core sits in LOAD and each
// cycle with prog_we high writes prog_data to imem[prog_addr]. Dropping
// prog_en starts execution from pc 0 on the next edge.
module multicycle_core
  import core_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PC_W    = 8,
  parameter int REG_AW  = 2,
  parameter int INSTR_W = 16,
  parameter int DMEM_AW = 8,
  parameter int PC_WRAP = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_en,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [REG_AW-1:0]  dbg_reg_sel,
  output logic [DATA_W-1:0]  dbg_reg_data,
  output logic [INSTR_W-1:0] dbg_instr,
  output logic [2:0]         flags,
  output logic [PC_W-1:0]    pc,
  output logic               halted,
  output logic               busy,
  output logic [31:0]        instr_retired,
  output logic [2:0]         dbg_state
);

  localparam int NREG     = 2 ** REG_AW;
  localparam int IMEM_D   = 2 ** PC_W;
  localparam int DMEM_D   = 2 ** DMEM_AW;
  localparam int OP_LSB   = op_lsb(INSTR_W);
  localparam int RD_LSB   = rd_lsb(INSTR_W, REG_AW);
  localparam int RS_LSB   = rs_lsb(INSTR_W, REG_AW);
  localparam int IMM_LSB  = imm_lsb(INSTR_W, REG_AW, DATA_W);
  localparam int TGT_LSB  = tgt_lsb(INSTR_W, PC_W);
  localparam int USED_LSB = used_lsb(INSTR_W, REG_AW, DATA_W, PC_W);
  localparam logic [PC_W-1:0] PC_MAX = '1;

  state_e                    state_q, state_d;
  logic [PC_W-1:0]           pc_q, pc_d, pc_inc;
  logic [2:0]                flags_q;
  logic [DATA_W-1:0]         rf_q [NREG];
  logic [INSTR_W-1:0]        imem_q [IMEM_D];
  logic [DATA_W-1:0]         dmem_q [DMEM_D];

  // Pipeline-ish holding registers between phases
  logic [INSTR_W-1:USED_LSB] fetch_q;
  logic [INSTR_W-1:USED_LSB] ir_q;
  logic [DATA_W-1:0]         opa_q, opb_q, mem_rd_q;

  // Decoded fields of the latched instruction
  logic [4:0]                op_w;
  logic [REG_AW-1:0]         rd_w;
  logic [DATA_W-1:0]         imm_w;
  logic [PC_W-1:0]           tgt_w;

  logic [DATA_W-1:0]         alu_b, alu_res;
  logic [2:0]                alu_flags;
  logic                      rf_we, flags_we, dm_we, jump_taken;
  logic [DATA_W-1:0]         rf_wd;
  logic [DMEM_AW-1:0]        dm_waddr, dm_raddr;

  assign op_w  = ir_q[OP_LSB +: OP_W];
  assign rd_w  = ir_q[RD_LSB +: REG_AW];
  assign imm_w = ir_q[IMM_LSB +: DATA_W];
  assign tgt_w = ir_q[TGT_LSB +: PC_W];

  // ST writes dmem[rd] = rs; LD reads dmem[rs]
  assign dm_waddr = DMEM_AW'(opa_q);
  assign dm_raddr = DMEM_AW'(opb_q);

  assign alu_b = (op_w == OP_ADDI || op_w == OP_LDI) ? imm_w : opb_q;

  core_alu #(.DATA_W(DATA_W)) u_alu (
    .op_i    (op_w),
    .a_i     (opa_q),
    .b_i     (alu_b),
    .result_o(alu_res),
    .flags_o (alu_flags)
  );

  // Next-state, PC update and write enables; prog_en overrides everything
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rf_we      = 1'b0;
    rf_wd      = alu_res;
    flags_we   = 1'b0;
    dm_we      = 1'b0;
    jump_taken = 1'b0;
    if (pc_q == PC_MAX) pc_inc = (PC_WRAP != 0) ? '0 : pc_q;
    else                pc_inc = pc_q + PC_W'(1);

    case (op_w)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = flags_q[FLAG_Z];
      OP_JNZ:  jump_taken = !flags_q[FLAG_Z];
      OP_JL:   jump_taken = flags_q[FLAG_L];
      OP_JG:   jump_taken = flags_q[FLAG_G];
      default: jump_taken = 1'b0;
    endcase

    if (prog_en) begin
      state_d = S_LOAD;
      pc_d    = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: state_d = S_EXEC;
        S_EXEC: begin
          rf_we    = writes_reg(op_w);
          flags_we = writes_flags(op_w);
          dm_we    = (op_w == OP_ST);
          if (op_w == OP_LD) begin
            state_d = S_MEM;
          end else if (op_w == OP_HLT) begin
            state_d = S_HALT;
          end else begin
            state_d = S_FETCH;
            pc_d    = jump_taken ? tgt_w : pc_inc;
          end
        end
        S_MEM: begin
          rf_we   = 1'b1;
          rf_wd   = mem_rd_q;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_FETCH;
      endcase
    end
  end

  // FSM state register; reset lands in LOAD if the loader already holds prog_en
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= prog_en ? S_LOAD : S_FETCH;
    else        state_q <= state_d;
  end

  // Architectural state: PC, flags, register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      flags_q <= '0;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else begin
      pc_q <= pc_d;
      if (flags_we) flags_q <= alu_flags;
      if (rf_we) rf_q[rd_w] <= rf_wd;
    end
  end

  // Memories and phase holding registers (not reset)
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD && prog_en && prog_we) imem_q[prog_addr] <= prog_data;
    if (state_q == S_FETCH) fetch_q <= imem_q[pc_q][INSTR_W-1:USED_LSB];
    if (state_q == S_DECODE) begin
      ir_q  <= fetch_q;
      opa_q <= rf_q[fetch_q[RD_LSB +: REG_AW]];
      opb_q <= rf_q[fetch_q[RS_LSB +: REG_AW]];
    end
    if (dm_we) dmem_q[dm_waddr] <= opb_q;
    if (state_q == S_EXEC) mem_rd_q <= dmem_q[dm_raddr];
  end

`ifdef CORE_PERF_CNT_EN
  logic [31:0] retired_q;
  logic        retire;

  // An instruction completes at EXEC (all but LD) or at MEM (LD)
  assign retire = !prog_en &&
                  ((state_q == S_EXEC && op_w != OP_LD) || state_q == S_MEM);

  // Saturating retired-instruction counter, cleared when entering LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          retired_q <= '0;
    else if (state_d == S_LOAD)          retired_q <= '0;
    else if (retire && retired_q != '1)  retired_q <= retired_q + 32'd1;
  end

  assign instr_retired = retired_q;
`else
  assign instr_retired = '0;
`endif

  assign dbg_reg_data = rf_q[dbg_reg_sel];
  assign dbg_instr    = imem_q[prog_addr];
  assign flags        = flags_q;
  assign pc           = pc_q;
  assign halted       = (state_q == S_HALT);
  assign busy         = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                        (state_q == S_EXEC)  || (state_q == S_MEM);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: hand-encoded programs with
// hand-computed register/flag/timing expectations.
module tb_multicycle_core;
  import core_pkg::*;

  localparam logic [4:0] NOP = 5'd0, LDI = 5'd2, ADD = 5'd3, SUB = 5'd4,
                         CMP = 5'd8, ADDI = 5'd9, LD = 5'd10, ST = 5'd11,
                         JZ = 5'd13, HLT = 5'd17;
`ifdef CORE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst_n, prog_en, prog_we;
  logic [7:0]  prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  dbg_reg_sel;
  logic [7:0]  dbg_reg_data, dbg_reg_data_w;
  logic [15:0] dbg_instr, dbg_instr_w;
  logic [2:0]  flags, flags_w;
  logic [7:0]  pc, pc_w;
  logic        halted, halted_w, busy, busy_w;
  logic [31:0] instr_retired, instr_retired_w;
  logic [2:0]  dbg_state, dbg_state_w;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] prog_q[$];

  multicycle_core dut (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_reg_sel(dbg_reg_sel),
    .dbg_reg_data(dbg_reg_data), .dbg_instr(dbg_instr), .flags(flags),
    .pc(pc), .halted(halted), .busy(busy), .instr_retired(instr_retired),
    .dbg_state(dbg_state)
  );

  multicycle_core #(.PC_WRAP(1)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_reg_sel(dbg_reg_sel),
    .dbg_reg_data(dbg_reg_data_w), .dbg_instr(dbg_instr_w), .flags(flags_w),
    .pc(pc_w), .halted(halted_w), .busy(busy_w), .instr_retired(instr_retired_w),
    .dbg_state(dbg_state_w)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [1:0] rd, input logic [1:0] rs);
    return {op, rd, rs, 7'd0};
  endfunction
  function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [1:0] rd, input logic [7:0] imm);
    return {op, rd, imm, 1'b0};
  endfunction
  function automatic logic [15:0] enc_j(input logic [4:0] op, input logic [7:0] tgt);
    return {op, tgt, 3'd0};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reg(input string tag, input int r, input logic [7:0] exp);
    dbg_reg_sel = 2'(r);
    #1;
    check_eq(tag, {24'd0, dbg_reg_data}, {24'd0, exp});
  endtask

  // Reset into LOAD (clears registers and flags)
  task automatic reset_to_load();
    @(negedge clk);
    prog_en = 1'b1;
    prog_we = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_prog();
    for (int i = 0; i < prog_q.size(); i++) begin
      @(negedge clk);
      prog_we   = 1'b1;
      prog_addr = 8'(i);
      prog_data = prog_q[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Release prog_en and count busy cycles until HALT
  task automatic run_prog(input string tag, output int busy_n);
    prog_en = 1'b0;
    busy_n  = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (halted) break;
      if (busy) busy_n++;
    end
    check_eq({tag, "_halted"}, {31'd0, halted}, 32'd1);
  endtask

  // Wait (bounded) for a given pc/state pair; stays at that negedge
  task automatic wait_at(input string tag, input logic [7:0] p, input logic [2:0] s);
    logic found;
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (pc == p && dbg_state == s) begin
        found = 1'b1;
        break;
      end
    end
    check_eq({tag, "_reached"}, {31'd0, found}, 32'd1);
  endtask

  initial begin
    int bn;
    logic seen_w, a_hit, a_left;
    logic [7:0] prev_w, after_w;

    rst_n = 1'b0; prog_en = 1'b0; prog_we = 1'b0;
    prog_addr = '0; prog_data = '0; dbg_reg_sel = '0;

    // Reset with prog_en low lands in FETCH
    repeat (2) @(negedge clk);
    check_eq("rst_state_fetch", {29'd0, dbg_state}, {29'd0, S_FETCH});
    check_eq("rst_busy", {31'd0, busy}, 32'd1);
    // Reset with prog_en high lands in LOAD
    prog_en = 1'b1;
    @(negedge clk);
    check_eq("rst_state_load", {29'd0, dbg_state}, {29'd0, S_LOAD});
    check_eq("rst_pc", {24'd0, pc}, 32'd0);
    check_eq("rst_flags", {29'd0, flags}, 32'd0);
    check_eq("rst_halted", {31'd0, halted}, 32'd0);
    check_eq("rst_retired", instr_retired, 32'd0);
    for (int r = 0; r < 4; r++) check_reg($sformatf("rst_r%0d", r), r, 8'h00);
    rst_n = 1'b1;

    // A: add program
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'd5), enc_i(LDI, 1, 8'd3), enc_r(ADD, 0, 1), enc_r(HLT, 0, 0)};
    load_prog();
    prog_addr = 8'd2;
    #1;
    check_eq("a_dbg_instr", {16'd0, dbg_instr}, {16'd0, enc_r(ADD, 0, 1)});
    run_prog("a", bn);
    check_eq("a_busy_cycles", bn, 32'd12);
    check_reg("a_r0", 0, 8'd8);
    check_reg("a_r1", 1, 8'd3);
    check_eq("a_flags", {29'd0, flags}, 32'd0);
    check_eq("a_pc", {24'd0, pc}, 32'd3);
    check_eq("a_retired", instr_retired, PERF ? 32'd4 : 32'd0);

    // B: compare and conditional jump
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'd3), enc_i(LDI, 1, 8'd3), enc_r(CMP, 0, 1), enc_j(JZ, 8'd6),
               enc_i(LDI, 2, 8'd1), enc_r(HLT, 0, 0), enc_i(LDI, 2, 8'd2), enc_r(HLT, 0, 0)};
    load_prog();
    run_prog("b", bn);
    check_eq("b_busy_cycles", bn, 32'd18);
    check_reg("b_r2", 2, 8'd2);
    check_reg("b_r0", 0, 8'd3);
    check_eq("b_flags", {29'd0, flags}, 32'b100);
    check_eq("b_pc", {24'd0, pc}, 32'd7);

    // C: store then load
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'h10), enc_i(LDI, 1, 8'hAB), enc_r(ST, 0, 1), enc_r(LD, 2, 0),
               enc_r(HLT, 0, 0)};
    load_prog();
    run_prog("c", bn);
    check_eq("c_busy_cycles", bn, 32'd16);
    check_reg("c_r2", 2, 8'hAB);
    check_eq("c_retired", instr_retired, PERF ? 32'd5 : 32'd0);

    // D: ADDI overflow wraps to zero
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'hFF), enc_i(ADDI, 0, 8'd1), enc_r(HLT, 0, 0)};
    load_prog();
    run_prog("d", bn);
    check_reg("d_r0", 0, 8'h00);
    check_eq("d_flags", {29'd0, flags}, 32'b100);

    // E: SUB borrow
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'd2), enc_i(LDI, 1, 8'd5), enc_r(SUB, 0, 1), enc_r(HLT, 0, 0)};
    load_prog();
    run_prog("e", bn);
    check_reg("e_r0", 0, 8'hFD);
    check_reg("e_r1", 1, 8'd5);
    check_eq("e_flags", {29'd0, flags}, 32'b010);

    // F: prog_en during DECODE of ADD
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'd5), enc_i(LDI, 1, 8'd3), enc_r(ADD, 0, 1), enc_r(HLT, 0, 0)};
    load_prog();
    prog_en = 1'b0;
    wait_at("f", 8'd2, S_DECODE);
    prog_en = 1'b1;
    @(negedge clk);
    check_eq("f_state", {29'd0, dbg_state}, {29'd0, S_LOAD});
    check_eq("f_pc", {24'd0, pc}, 32'd0);
    check_reg("f_r0", 0, 8'd5);
    check_eq("f_retired", instr_retired, 32'd0);

    // G: prog_en during EXEC of SUB suppresses writeback and flags
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'd2), enc_i(LDI, 1, 8'd5), enc_r(SUB, 0, 1), enc_r(HLT, 0, 0)};
    load_prog();
    prog_en = 1'b0;
    wait_at("g", 8'd2, S_EXEC);
    prog_en = 1'b1;
    @(negedge clk);
    check_eq("g_state", {29'd0, dbg_state}, {29'd0, S_LOAD});
    check_eq("g_pc", {24'd0, pc}, 32'd0);
    check_reg("g_r0", 0, 8'd2);
    check_eq("g_flags", {29'd0, flags}, 32'd0);

    // H: asynchronous reset in the middle of EXEC
    reset_to_load();
    prog_q = '{enc_i(LDI, 0, 8'd2), enc_i(LDI, 1, 8'd5), enc_r(SUB, 0, 1), enc_r(ADD, 0, 1),
               enc_r(HLT, 0, 0)};
    load_prog();
    prog_en = 1'b0;
    wait_at("h", 8'd3, S_EXEC);
    check_eq("h_flags_before", {29'd0, flags}, 32'b010);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("h_flags", {29'd0, flags}, 32'd0);
    check_eq("h_pc", {24'd0, pc}, 32'd0);
    check_reg("h_r0", 0, 8'd0);
    check_reg("h_r1", 1, 8'd0);
    prog_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // I: NOP-filled memory, saturate vs wrap at end of memory
    reset_to_load();
    prog_q.delete();
    for (int i = 0; i < 256; i++) prog_q.push_back(enc_r(NOP, 0, 0));
    load_prog();
    prog_en = 1'b0;
    seen_w = 1'b0; a_hit = 1'b0; a_left = 1'b0;
    prev_w = 8'd0; after_w = 8'hEE;
    for (int c = 0; c < 256 * 3 + 30; c++) begin
      @(negedge clk);
      if (a_hit && pc != 8'd255) a_left = 1'b1;
      if (pc == 8'd255) a_hit = 1'b1;
      if (!seen_w && prev_w == 8'd255 && pc_w != 8'd255) begin
        seen_w  = 1'b1;
        after_w = pc_w;
      end
      prev_w = pc_w;
    end
    check_eq("i_sat_reached", {31'd0, a_hit}, 32'd1);
    check_eq("i_sat_left", {31'd0, a_left}, 32'd0);
    check_eq("i_sat_pc", {24'd0, pc}, 32'd255);
    check_eq("i_sat_busy", {31'd0, busy}, 32'd1);
    check_eq("i_wrap_seen", {31'd0, seen_w}, 32'd1);
    check_eq("i_wrap_pc", {24'd0, after_w}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
